// File: rtl/disp_rd_sched_pkg.sv
// rtl/disp_rd_sched_pkg.sv - shared display package: LCD timing, frame constants, read-scheduler states
package disp_rd_sched_pkg;

    // Lcd_Para: 640x480 @ 60 Hz timing with a 25 MHz pixel clock
    localparam int H_SYNC   = 96;
    localparam int H_BACK   = 48;
    localparam int H_ACTIVE = 640;
    localparam int H_FRONT  = 16;
    localparam int H_TOTAL  = H_SYNC + H_BACK + H_ACTIVE + H_FRONT;
    localparam int V_SYNC   = 2;
    localparam int V_BACK   = 33;
    localparam int V_ACTIVE = 480;
    localparam int V_FRONT  = 10;
    localparam int V_TOTAL  = V_SYNC + V_BACK + V_ACTIVE + V_FRONT;

    localparam int ADDR_W    = 22;
    localparam int FRAME_PIX = H_ACTIVE * V_ACTIVE;

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        CHECK,
        REQ,
        WAIT_DONE
    } rd_state_t;

endpackage

// File: rtl/disp_rd_sched.sv
// rtl/disp_rd_sched.sv - frame-buffer read scheduler: issues SDRAM bursts to keep the display FIFO fed
module disp_rd_sched
    import disp_rd_sched_pkg::*;
#(
    parameter logic [ADDR_W-1:0] FRAME_BASE   = 22'h000000,
    parameter int                FRAME_PIXELS = FRAME_PIX,
    parameter int                BURST_LEN    = 256,
    parameter int                FIFO_DEPTH   = 1024,
    parameter int                PRIME_LVL    = 512
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              frame_start,
    input  logic              disp_en,
    input  logic [10:0]       fifo_used,
    input  logic              rd_ack,
    input  logic              rd_done,
    output logic              rd_req,
    output logic [ADDR_W-1:0] rd_addr,
    output logic [8:0]        rd_len,
    output logic              fifo_clr,
    output logic              rfifo_rd_ready,
    output logic              underflow
);

    localparam logic [18:0] PIX_W   = 19'(FRAME_PIXELS);
    localparam logic [18:0] BURST_R = 19'(BURST_LEN);
    localparam logic [8:0]  BURST_L = 9'(BURST_LEN);
    localparam logic [11:0] BURST_F = 12'(BURST_LEN);
    localparam logic [11:0] DEPTH_F = 12'(FIFO_DEPTH);
    localparam logic [10:0] PRIME_F = 11'(PRIME_LVL);

    rd_state_t         state, state_nxt;
    logic              clr_cnt;
    logic [ADDR_W-1:0] addr;
    logic [18:0]       remaining;
    logic              pending_frame;
    logic [8:0]        burst_len;
    logic              fifo_room;
    logic              prime_hit;

    // The final burst of a frame is trimmed to what is left, so remaining cannot wrap
    assign burst_len = (remaining >= BURST_R) ? BURST_L : remaining[8:0];
    assign fifo_room = ({1'b0, fifo_used} + BURST_F) <= DEPTH_F;
    assign prime_hit = (fifo_used >= PRIME_F) || ((remaining == 19'd0) && (fifo_used != 11'd0));
    assign rd_addr   = addr;

    always_comb begin
        state_nxt = state;
        rd_req    = 1'b0;
        rd_len    = 9'd0;
        fifo_clr  = 1'b0;
        case (state)
            IDLE: begin
                if (frame_start) state_nxt = CLEAR;
            end
            CLEAR: begin
                fifo_clr = 1'b1;
                if (!frame_start && clr_cnt) state_nxt = CHECK;
            end
            CHECK: begin
                if (frame_start) state_nxt = CLEAR;
                else if ((remaining != 19'd0) && fifo_room) state_nxt = REQ;
            end
            REQ: begin
                rd_req = 1'b1;
                rd_len = burst_len;
                if (rd_ack) state_nxt = WAIT_DONE;
            end
            WAIT_DONE: begin
                if (rd_done) state_nxt = (pending_frame || frame_start) ? CLEAR : CHECK;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= IDLE;
            clr_cnt        <= 1'b0;
            addr           <= FRAME_BASE;
            remaining      <= 19'd0;
            pending_frame  <= 1'b0;
            rfifo_rd_ready <= 1'b0;
            underflow      <= 1'b0;
        end else begin
            state <= state_nxt;
            // A frame_start inside CLEAR restarts the two-cycle count
            clr_cnt <= (state == CLEAR && !frame_start) ? ~clr_cnt : 1'b0;
            if (state == CLEAR) begin
                addr           <= FRAME_BASE;
                remaining      <= PIX_W;
                pending_frame  <= 1'b0;
                rfifo_rd_ready <= 1'b0;
                underflow      <= 1'b0;
            end else if (state != IDLE) begin
                if (state == REQ && rd_ack) begin
                    addr      <= addr + {13'd0, burst_len};
                    remaining <= remaining - {10'd0, burst_len};
                end
                if ((state == REQ || state == WAIT_DONE) && frame_start) pending_frame <= 1'b1;
                if (prime_hit) rfifo_rd_ready <= 1'b1;
                if (disp_en && rfifo_rd_ready && fifo_used == 11'd0) underflow <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_disp_rd_sched.sv
// tb/tb_disp_rd_sched.sv - randomized bench for disp_rd_sched against a frame-level reference model
module tb_disp_rd_sched;

    localparam int          PIX   = 2000;
    localparam int          BURST = 256;
    localparam int          DEPTH = 1024;
    localparam int          PRIME = 512;
    localparam logic [21:0] BASE  = 22'h000000;

    logic        clk = 1'b0;
    logic        rst;
    logic        frame_start;
    logic        disp_en;
    logic [10:0] fifo_used;
    logic        rd_ack;
    logic        rd_done;
    logic        rd_req;
    logic [21:0] rd_addr;
    logic [8:0]  rd_len;
    logic        fifo_clr;
    logic        rfifo_rd_ready;
    logic        underflow;

    always #20 clk = ~clk;

    disp_rd_sched #(
        .FRAME_BASE  (BASE),
        .FRAME_PIXELS(PIX),
        .BURST_LEN   (BURST),
        .FIFO_DEPTH  (DEPTH),
        .PRIME_LVL   (PRIME)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .frame_start   (frame_start),
        .disp_en       (disp_en),
        .fifo_used     (fifo_used),
        .rd_ack        (rd_ack),
        .rd_done       (rd_done),
        .rd_req        (rd_req),
        .rd_addr       (rd_addr),
        .rd_len        (rd_len),
        .fifo_clr      (fifo_clr),
        .rfifo_rd_ready(rfifo_rd_ready),
        .underflow     (underflow)
    );

    int          n_cmp = 0;
    int          n_bad = 0;
    int          level = 0;
    int          phase = 0;
    int          ack_wait, done_wait;
    int          ack_hold = -1;
    int          done_force = -1;
    int          cur_len;
    int          exp_rem = 0;
    int          bursts = 0;
    int          clr_run = 0;
    int          exp_run = 2;
    logic [21:0] cap_addr, exp_addr;
    logic [8:0]  cap_len;
    bit          pend, clr_due, prev_clr, cond_seen, uf_seen, frame_active;
    bit          drain_on, force_de, force_empty, fs_req, de;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // One clock: sample at negedge, run the environment and model, update FIFO level after the edge
    task automatic step();
        bit clr_now;
        @(negedge clk);
        clr_now = fifo_clr;
        if (clr_due || (clr_now && !prev_clr)) check("clr_entry", 64'(clr_now), 64'(clr_due));
        clr_due = 1'b0;
        if (clr_now) begin
            clr_run++;
            exp_addr     = BASE;
            exp_rem      = PIX;
            bursts       = 0;
            cond_seen    = 1'b0;
            uf_seen      = 1'b0;
            pend         = 1'b0;
            frame_active = 1'b1;
        end else begin
            if (prev_clr) begin
                check("clr_len", 64'(clr_run), 64'(exp_run));
                clr_run = 0;
                exp_run = 2;
            end
            check("ready", 64'(rfifo_rd_ready), 64'(cond_seen));
            check("underflow", 64'(underflow), 64'(uf_seen));
        end
        prev_clr = clr_now;

        de      = force_de || (drain_on && rfifo_rd_ready && level > 0 && $urandom_range(3) != 0);
        disp_en = de;
        if (frame_active && !clr_now) begin
            if (de && cond_seen && level == 0) uf_seen = 1'b1;
            if (level >= PRIME || (exp_rem == 0 && level > 0)) cond_seen = 1'b1;
        end

        rd_ack  = 1'b0;
        rd_done = 1'b0;
        if (phase == 1) check("req_hold", {rd_req, rd_addr, rd_len}, {1'b1, cap_addr, cap_len});
        if (phase == 0 && rd_req) begin
            cur_len = (exp_rem >= BURST) ? BURST : exp_rem;
            check("req_pending", 64'(pend), 64'd0);
            check("req_remaining", 64'(exp_rem > 0), 64'd1);
            check("burst_addr", 64'(rd_addr), 64'(exp_addr));
            check("burst_len", 64'(rd_len), 64'(cur_len));
            check("fifo_room", 64'((level + int'(rd_len)) <= DEPTH), 64'd1);
            cap_addr = rd_addr;
            cap_len  = rd_len;
            ack_wait = (ack_hold >= 0) ? ack_hold : int'($urandom_range(5));
            phase    = 1;
        end
        if (phase == 1) begin
            if (ack_wait == 0) begin
                rd_ack    = 1'b1;
                exp_addr  = exp_addr + 22'(cur_len);
                exp_rem   = exp_rem - cur_len;
                bursts++;
                phase     = 2;
                done_wait = (done_force >= 0) ? done_force - 1 : int'($urandom_range(8, 1));
            end else begin
                ack_wait--;
            end
        end else if (phase == 2) begin
            if (done_wait == 0) begin
                rd_done = 1'b1;
                phase   = 0;
                if (pend) begin
                    clr_due = 1'b1;
                    pend    = 1'b0;
                end
            end else begin
                done_wait--;
            end
        end

        frame_start = fs_req;
        if (fs_req) begin
            if (clr_now) exp_run = clr_run + 2;
            else if (rd_done || phase == 0) begin
                clr_due = 1'b1;
                pend    = 1'b0;
            end else pend = 1'b1;
            fs_req = 1'b0;
        end

        @(posedge clk);
        #1;
        if (clr_now) level = 0;
        else begin
            if (de && level > 0) level--;
            if (rd_done) level += int'(cap_len);
        end
        if (force_empty) level = 0;
        fifo_used = 11'(level);
    endtask

    task automatic wait_clr(input string tag);
        int i;
        for (i = 0; i < 60 && !prev_clr; i++) step();
        check(tag, 64'(prev_clr), 64'd1);
    endtask

    initial begin
        rst = 1'b1;
        frame_start = 1'b0;
        disp_en = 1'b0;
        fifo_used = 11'd0;
        rd_ack = 1'b0;
        rd_done = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_rd_req", 64'(rd_req), 64'd0);
        check("rst_rd_addr", 64'(rd_addr), 64'(BASE));
        check("rst_rd_len", 64'(rd_len), 64'd0);
        check("rst_fifo_clr", 64'(fifo_clr), 64'd0);
        check("rst_ready", 64'(rfifo_rd_ready), 64'd0);
        check("rst_underflow", 64'(underflow), 64'd0);
        rst = 1'b0;
        repeat (5) step();

        // No draining: four bursts fill the FIFO, then the scheduler must stall
        fs_req = 1'b1;
        for (int i = 0; i < 800 && !(bursts >= 4 && phase == 0); i++) step();
        check("fill_timeout", 64'(bursts >= 4 && phase == 0), 64'd1);
        repeat (100) step();
        check("stall_bursts", 64'(bursts), 64'd4);
        check("stall_level", 64'(level), 64'(DEPTH));
        check("stall_no_req", 64'(rd_req), 64'd0);

        // Drain to the end of the frame: 7 full bursts plus a trimmed 208-pixel one
        drain_on = 1'b1;
        for (int i = 0; i < 20000 && !(exp_rem == 0 && phase == 0); i++) step();
        check("frame_timeout", 64'(exp_rem == 0 && phase == 0), 64'd1);
        check("frame_bursts", 64'(bursts), 64'd8);
        repeat (50) step();
        check("end_no_req", 64'(rd_req), 64'd0);
        check("end_ready", 64'(rfifo_rd_ready), 64'd1);
        check("end_no_uf", 64'(underflow), 64'd0);

        // Ack withheld for 50 cycles on the first burst of a frame
        ack_hold = 50;
        fs_req = 1'b1;
        step();
        wait_clr("hold_clr_timeout");
        for (int i = 0; i < 600 && bursts < 1; i++) step();
        check("hold_timeout", 64'(bursts >= 1), 64'd1);
        ack_hold = -1;

        // frame_start during WAIT_DONE with rd_done 10 cycles after ack
        done_force = 10;
        for (int i = 0; i < 800 && phase != 1; i++) step();
        for (int i = 0; i < 50 && phase != 2; i++) step();
        check("wd_timeout", 64'(phase), 64'd2);
        fs_req = 1'b1;
        step();
        wait_clr("wd_clr_timeout");
        done_force = -1;

        // frame_start on the second CLEAR cycle stretches the clear to four cycles
        for (int i = 0; i < 100; i++) step();
        fs_req = 1'b1;
        step();
        wait_clr("restart_clr_timeout");
        fs_req = 1'b1;
        repeat (10) step();

        // Forced underflow after priming: sticky until the next CLEAR
        for (int i = 0; i < 3000 && !rfifo_rd_ready; i++) step();
        check("prime_timeout", 64'(rfifo_rd_ready), 64'd1);
        drain_on = 1'b0;
        force_empty = 1'b1;
        repeat (3) step();
        force_de = 1'b1;
        repeat (5) step();
        check("uf_set", 64'(underflow), 64'd1);
        force_de = 1'b0;
        repeat (20) step();
        check("uf_sticky", 64'(underflow), 64'd1);
        force_empty = 1'b0;
        fs_req = 1'b1;
        step();
        wait_clr("uf_clr_timeout");
        repeat (4) step();
        check("uf_cleared", 64'(underflow), 64'd0);

        // Random traffic with occasional frame_start at arbitrary points
        drain_on = 1'b1;
        for (int i = 0; i < 5000; i++) begin
            if ($urandom_range(599) == 0) fs_req = 1'b1;
            step();
        end
        fs_req = 1'b1;
        step();
        wait_clr("final_clr_timeout");
        for (int i = 0; i < 20000 && !(exp_rem == 0 && phase == 0); i++) step();
        check("final_timeout", 64'(exp_rem == 0 && phase == 0), 64'd1);
        check("final_bursts", 64'(bursts), 64'd8);
        repeat (20) step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
